lvds_pixel_mapper: RTL and testbench

Parametrised LVDS transmit-side pixel mapper: takes PIXELS pixels per clock of 8-bit RGB plus syncs and packs them into 7-bit lane words (4 lanes per pixel) for the 7:1 serializers. It sits between the video timing/framebuffer readout and the LVDS TX primitives. Over the fixed single-port, VESA-only predecessor, it adds selectable VESA/JEIDA bit mapping, sync polarity control, a frame-latched test-pattern generator and a line-length monitor.

---
 rtl/lvds_pixel_mapper.sv | 197 +++++++++++++++++++
 tb/tb_lvds_pixel_mapper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_pixel_mapper.sv
// LVDS transmit pixel mapper: blank/pattern select stage, then VESA/JEIDA lane packing.
// Also latches the test pattern once per frame and monitors active line length.
module lvds_pixel_mapper #(
  parameter int unsigned PIXELS    = 2,
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned BAR_SHIFT = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_vsync,
  input  logic                  in_hsync,
  input  logic                  in_de,
  input  logic [8*PIXELS-1:0]   in_data_r,
  input  logic [8*PIXELS-1:0]   in_data_g,
  input  logic [8*PIXELS-1:0]   in_data_b,
  input  logic                  map_jeida,
  input  logic                  hs_inv,
  input  logic                  vs_inv,
  input  logic [1:0]            pattern_sel,
  input  logic [23:0]           pattern_rgb,
  input  logic                  line_err_clr,
  output logic [28*PIXELS-1:0]  out_data,
  output logic [6:0]            out_clk,
  output logic [LEN_W-1:0]      line_len,
  output logic                  line_err
);

  typedef enum logic [1:0] {
    PAT_PASS  = 2'd0,
    PAT_SOLID = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_RAMP  = 2'd3
  } pat_e;

  pat_e                 pat_q;
  logic [7:0]           frame_cnt;
  logic                 vs_prev;
  logic                 vs_rise;
  logic [LEN_W-1:0]     x_cnt;

  logic [8*PIXELS-1:0]  s0_r, s0_g, s0_b;
  logic [8*PIXELS-1:0]  s1_r, s1_g, s1_b;
  logic                 s1_hs, s1_vs, s1_de, s1_jeida;
  logic [28*PIXELS-1:0] map_nxt;

  logic                 de_prev;
  logic                 de_fall;
  logic                 have_prev;
  logic [LEN_W-1:0]     beat_cnt;
  logic [LEN_W-1:0]     prev_len;

  assign out_clk = 7'b1100011;
  assign vs_rise = in_vsync & ~vs_prev;
  assign de_fall = ~in_de & de_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev   <= 1'b0;
      pat_q     <= PAT_PASS;
      frame_cnt <= '0;
      x_cnt     <= '0;
    end else begin
      vs_prev <= in_vsync;
      if (vs_rise) begin
        pat_q     <= pat_e'(pattern_sel);
        frame_cnt <= frame_cnt + 8'd1;
      end
      x_cnt <= in_de ? x_cnt + LEN_W'(PIXELS) : '0;
    end
  end

  // Colour bar order white..black falls out of inverted bar index bits: R=~b1, G=~b2, B=~b0.
  always_comb begin : pixel_select
    logic [LEN_W-1:0] x;
    logic [2:0]       bar;
    logic [7:0]       ramp;
    s0_r = '0;
    s0_g = '0;
    s0_b = '0;
    x    = '0;
    bar  = '0;
    ramp = '0;
    for (int unsigned p = 0; p < PIXELS; p++) begin
      x    = x_cnt + LEN_W'(p);
      bar  = 3'(x >> BAR_SHIFT);
      ramp = 8'(x) + frame_cnt;
      if (in_de) begin
        case (pat_q)
          PAT_SOLID: begin
            s0_r[p*8 +: 8] = pattern_rgb[23:16];
            s0_g[p*8 +: 8] = pattern_rgb[15:8];
            s0_b[p*8 +: 8] = pattern_rgb[7:0];
          end
          PAT_BARS: begin
            s0_r[p*8 +: 8] = {8{~bar[1]}};
            s0_g[p*8 +: 8] = {8{~bar[2]}};
            s0_b[p*8 +: 8] = {8{~bar[0]}};
          end
          PAT_RAMP: begin
            s0_r[p*8 +: 8] = ramp;
            s0_g[p*8 +: 8] = ramp;
            s0_b[p*8 +: 8] = ramp;
          end
          default: begin
            s0_r[p*8 +: 8] = in_data_r[p*8 +: 8];
            s0_g[p*8 +: 8] = in_data_g[p*8 +: 8];
            s0_b[p*8 +: 8] = in_data_b[p*8 +: 8];
          end
        endcase
      end
    end
  end

  function automatic logic [27:0] map_pixel(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b,
    input logic       hs,
    input logic       vs,
    input logic       de,
    input logic       jeida
  );
    logic [6:0] la, lb, lc, ld;
    if (jeida) begin
      la = {r[2], r[3], r[4], r[5], r[6], r[7], g[2]};
      lb = {g[3], g[4], g[5], g[6], g[7], b[2], b[3]};
      lc = {b[4], b[5], b[6], b[7], hs, vs, de};
      ld = {r[0], r[1], g[0], g[1], b[0], b[1], 1'b0};
    end else begin
      la = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
      lb = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
      lc = {b[2], b[3], b[4], b[5], hs, vs, de};
      ld = {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
    end
    return {ld, lc, lb, la};
  endfunction

  // map_jeida travels with its beat so a blanking-time switch never remaps in-flight pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_de    <= 1'b0;
      s1_jeida <= 1'b0;
      out_data <= '0;
    end else begin
      s1_r     <= s0_r;
      s1_g     <= s0_g;
      s1_b     <= s0_b;
      s1_hs    <= in_hsync ^ hs_inv;
      s1_vs    <= in_vsync ^ vs_inv;
      s1_de    <= in_de;
      s1_jeida <= map_jeida;
      out_data <= map_nxt;
    end
  end

  always_comb begin
    map_nxt = '0;
    for (int unsigned p = 0; p < PIXELS; p++) begin
      map_nxt[p*28 +: 28] = map_pixel(s1_r[p*8 +: 8], s1_g[p*8 +: 8], s1_b[p*8 +: 8],
                                      s1_hs, s1_vs, s1_de, s1_jeida);
    end
  end

  // A vsync rise forgets the previous line so the first line of each frame is never compared.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_prev   <= 1'b0;
      beat_cnt  <= '0;
      prev_len  <= '0;
      have_prev <= 1'b0;
      line_len  <= '0;
      line_err  <= 1'b0;
    end else begin
      de_prev  <= in_de;
      beat_cnt <= in_de ? beat_cnt + LEN_W'(1) : '0;
      if (de_fall) begin
        line_len  <= beat_cnt;
        prev_len  <= beat_cnt;
        have_prev <= 1'b1;
      end
      if (vs_rise) begin
        have_prev <= 1'b0;
      end
      if (de_fall && have_prev && (beat_cnt != prev_len)) begin
        line_err <= 1'b1;
      end else if (line_err_clr) begin
        line_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lvds_pixel_mapper.sv
// Randomised scoreboard bench for lvds_pixel_mapper: a table-driven reference model
// predicts lane words and line statistics; a monitor pops and compares every cycle.
module tb_lvds_pixel_mapper;
  localparam int unsigned PIXELS    = 2;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned BAR_SHIFT = 5;
  localparam int unsigned OW        = 28 * PIXELS;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_vsync = 1'b0, in_hsync = 1'b0, in_de = 1'b0;
  logic [8*PIXELS-1:0]  in_data_r = '0, in_data_g = '0, in_data_b = '0;
  logic                 map_jeida = 1'b0, hs_inv = 1'b0, vs_inv = 1'b0;
  logic [1:0]           pattern_sel = 2'd0;
  logic [23:0]          pattern_rgb = 24'h123456;
  logic                 line_err_clr = 1'b0;
  logic [OW-1:0]        out_data;
  logic [6:0]           out_clk;
  logic [LEN_W-1:0]     line_len;
  logic                 line_err;

  always #5 clk = ~clk;

  lvds_pixel_mapper #(.PIXELS(PIXELS), .LEN_W(LEN_W), .BAR_SHIFT(BAR_SHIFT)) dut (
    .clk(clk), .reset(reset),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .in_data_r(in_data_r), .in_data_g(in_data_g), .in_data_b(in_data_b),
    .map_jeida(map_jeida), .hs_inv(hs_inv), .vs_inv(vs_inv),
    .pattern_sel(pattern_sel), .pattern_rgb(pattern_rgb), .line_err_clr(line_err_clr),
    .out_data(out_data), .out_clk(out_clk), .line_len(line_len), .line_err(line_err)
  );

  int total = 0;
  int bad   = 0;

  // Source index per lane bit (lane A bit6 first .. lane D bit0): 0-7 R, 8-15 G, 16-23 B, 24 HS, 25 VS, 26 DE, 27 zero.
  int vesa_src[28]  = '{0, 1, 2, 3, 4, 5, 8,   9, 10, 11, 12, 13, 16, 17,
                        18, 19, 20, 21, 24, 25, 26,   6, 7, 14, 15, 22, 23, 27};
  int jeida_src[28] = '{2, 3, 4, 5, 6, 7, 10,  11, 12, 13, 14, 15, 18, 19,
                        20, 21, 22, 23, 24, 25, 26,   0, 1, 8, 9, 16, 17, 27};
  logic [23:0] bar_rgb[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic [OW-1:0]  exp_q[$];
  logic [LEN_W:0] ln_q[$];

  int m_vs_prev, m_pat, m_frame, m_x, m_de_prev, m_cnt, m_prev_len, m_have_prev, m_len, m_err;
  bit rand_pat = 0;
  bit rand_clr = 0;
  bit force_clr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vs_prev = 0; m_pat = 0; m_frame = 0; m_x = 0; m_de_prev = 0;
    m_cnt = 0; m_prev_len = 0; m_have_prev = 0; m_len = 0; m_err = 0;
  endtask

  task automatic model_beat();
    logic [OW-1:0] w;
    logic [27:0]   src;
    logic [23:0]   rgb;
    int            x, v, idx, lane, bpos;
    bit            rise, fall;
    w = '0;
    for (int p = 0; p < PIXELS; p++) begin
      x = (m_x + p) % (1 << LEN_W);
      v = (x + m_frame) % 256;
      if (!in_de) rgb = '0;
      else begin
        case (m_pat)
          0: rgb = {in_data_r[p*8 +: 8], in_data_g[p*8 +: 8], in_data_b[p*8 +: 8]};
          1: rgb = pattern_rgb;
          2: rgb = bar_rgb[(x >> BAR_SHIFT) % 8];
          default: rgb = {3{v[7:0]}};
        endcase
      end
      src = {1'b0, in_de, in_vsync ^ vs_inv, in_hsync ^ hs_inv, rgb[7:0], rgb[15:8], rgb[23:16]};
      for (int k = 0; k < 28; k++) begin
        lane = k / 7;
        bpos = 6 - (k % 7);
        idx  = map_jeida ? jeida_src[k] : vesa_src[k];
        w[p*28 + lane*7 + bpos] = src[idx];
      end
    end
    exp_q.push_back(w);

    rise = in_vsync && (m_vs_prev == 0);
    fall = !in_de && (m_de_prev != 0);
    if (fall && m_have_prev != 0 && m_cnt != m_prev_len) m_err = 1;
    else if (line_err_clr) m_err = 0;
    if (fall) begin
      m_len = m_cnt; m_prev_len = m_cnt; m_have_prev = 1;
    end
    if (rise) begin
      m_have_prev = 0; m_pat = pattern_sel; m_frame = (m_frame + 1) % 256;
    end
    m_cnt     = in_de ? (m_cnt + 1) % (1 << LEN_W) : 0;
    m_de_prev = in_de;
    m_vs_prev = in_vsync;
    m_x       = in_de ? (m_x + PIXELS) % (1 << LEN_W) : 0;
    ln_q.push_back({m_err[0], m_len[LEN_W-1:0]});
  endtask

  task automatic beat(input logic vs, input logic hs, input logic de);
    @(negedge clk);
    reset    = 1'b0;
    in_vsync = vs;
    in_hsync = hs;
    in_de    = de;
    for (int p = 0; p < PIXELS; p++) begin
      in_data_r[p*8 +: 8] = 8'($urandom);
      in_data_g[p*8 +: 8] = 8'($urandom);
      in_data_b[p*8 +: 8] = 8'($urandom);
    end
    hs_inv = 1'($urandom_range(0, 1));
    vs_inv = 1'($urandom_range(0, 1));
    if (!de && $urandom_range(0, 15) == 0) map_jeida = ~map_jeida;
    if ($urandom_range(0, 63) == 0) pattern_rgb = 24'($urandom);
    if (rand_pat && $urandom_range(0, 99) == 0) pattern_sel = 2'($urandom);
    line_err_clr = force_clr || (rand_clr && $urandom_range(0, 9) == 0);
    model_beat();
  endtask

  task automatic active(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b1);
  endtask

  task automatic gap(input bit clr);
    force_clr = clr;
    beat(1'b0, 1'b1, 1'b0);
    force_clr = 0;
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input int n, input bit clr);
    active(n);
    gap(clr);
  endtask

  task automatic vsync();
    repeat (3) beat(1'b1, 1'b0, 1'b0);
    repeat (2) beat(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    ln_q.delete();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_line_len", 64'(line_len), 64'd0);
      check("rst_line_err", 64'(line_err), 64'd0);
      check("rst_out_clk", 64'(out_clk), 64'h63);
    end
    model_reset();
  endtask

  initial begin : monitor
    logic [LEN_W:0] lv;
    logic [OW-1:0]  ov;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (ln_q.size() >= 1) begin
          lv = ln_q.pop_front();
          check("line_len", 64'(line_len), 64'(lv[LEN_W-1:0]));
          check("line_err", 64'(line_err), 64'(lv[LEN_W]));
        end
        if (exp_q.size() >= 2) begin
          ov = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(ov));
        end
        check("out_clk", 64'(out_clk), 64'h63);
      end
    end
  end

  initial begin : stimulus
    int base;
    model_reset();
    do_reset(3);

    vsync(); line(12, 0); line(12, 0); line(12, 0);
    vsync(); line(12, 0); pattern_sel = 2'd2; line(12, 0); line(10, 0); line(10, 1);
    vsync(); line(130, 0); line(130, 0);
    pattern_sel = 2'd3;
    vsync(); line(130, 0);
    vsync(); line(130, 0);
    vsync(); line(130, 0); line(131, 1); line(131, 0);

    active(20);
    do_reset(2);
    active(30); gap(0);
    line(12, 0); line(12, 1);

    pattern_sel = 2'd1;
    vsync(); line(960, 0); line(960, 0); line(958, 0); line(958, 1);

    rand_pat = 1;
    rand_clr = 1;
    for (int f = 0; f < 6; f++) begin
      base = $urandom_range(8, 140);
      vsync();
      for (int l = 0; l < 5; l++) line(base + (($urandom_range(0, 3) == 0) ? 1 : 0), 0);
    end
    rand_clr = 0;
    repeat (4) beat(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
